// File: rtl/edge_timestamp_fifo.sv
// rtl/edge_timestamp_fifo.sv - trigger-time capture with interval, queued in a show-ahead FIFO
module edge_timestamp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic [WIDTH-1:0]         counter,
  input  logic                     rd_en,
  input  logic                     clear_ovf,
  output logic [WIDTH-1:0]         rd_stamp,
  output logic [WIDTH-1:0]         rd_delta,
  output logic                     rd_first,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WIDTH-1:0]  prev_stamp;
  logic              have_prev;
  logic [WIDTH-1:0]  stamp_mem [DEPTH];
  logic [WIDTH-1:0]  delta_mem [DEPTH];
  logic              first_mem [DEPTH];

  logic              pop;
  logic              push;
  logic              drop;
  logic [WIDTH-1:0]  new_delta;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop       = rd_en & ~empty;
  assign push      = trigger & (~full | pop);
  assign drop      = trigger & full & ~pop;
  assign new_delta = have_prev ? (counter - prev_stamp) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev_stamp <= '0;
      have_prev  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Dropped captures still advance prev_stamp so deltas span adjacent edges.
      if (trigger) begin
        prev_stamp <= counter;
        have_prev  <= 1'b1;
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stamp_mem[wr_ptr[AW-1:0]] <= counter;
      delta_mem[wr_ptr[AW-1:0]] <= new_delta;
      first_mem[wr_ptr[AW-1:0]] <= ~have_prev;
    end
  end

  // Gate to zero when empty so the storage itself needs no reset.
  assign rd_stamp = empty ? '0   : stamp_mem[rd_ptr[AW-1:0]];
  assign rd_delta = empty ? '0   : delta_mem[rd_ptr[AW-1:0]];
  assign rd_first = empty ? 1'b0 : first_mem[rd_ptr[AW-1:0]];

endmodule
